// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the wait-state SRAM slave FSM state set.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } sram_state_e;

endpackage

// File: rtl/ahb3lite_be_mem.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module ahb3lite_be_mem #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DW/8; b++) begin
            if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with a fixed number of wait states per OKAY transfer
// and the two-cycle ERROR response for out-of-range or malformed accesses.
module ahb3lite_sram_ws
    import ahb3lite_pkg::*;
#(
    parameter int                    HADDR_SIZE  = 32,
    parameter int                    HDATA_SIZE  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WAIT_STATES = 0,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR   = '0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES = HDATA_SIZE / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE-1:0] MEM_BYTES = HADDR_SIZE'(MEM_DEPTH * BYTES);
    localparam logic [2:0] MAX_SIZE = 3'(BW);
    localparam logic [3:0] WS_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    sram_state_e           state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [AW-1:0]         widx_q, widx_d;
    logic [BW-1:0]         boff_q, boff_d;

    logic [HADDR_SIZE-1:0] offset, align_mask;
    logic                  xfer, err;
    logic [BYTES-1:0]      be;
    logic [HDATA_SIZE-1:0] rdata;
    logic                  unused_ok;

    assign unused_ok  = ^{HBURST, HPROT};

    assign xfer       = HSEL && HREADY &&
                        (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign offset     = HADDR - BASE_ADDR;
    assign align_mask = (HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1);
    assign err        = (HADDR < BASE_ADDR) || (offset >= MEM_BYTES) ||
                        ((HADDR & align_mask) != '0) || (HSIZE > MAX_SIZE);
    assign widx_d     = offset[AW+BW-1:BW];
    assign boff_d     = offset[BW-1:0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            widx_q  <= '0;
            boff_q  <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == '0) state_q <= ST_DATA;
                    else             cnt_q   <= cnt_q - 4'd1;
                end
                ST_ERR1: state_q <= ST_ERR2;
                default: begin
                    if (xfer) begin
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        widx_q  <= widx_d;
                        boff_q  <= boff_d;
                        if (err) begin
                            state_q <= ST_ERR1;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WS_LOAD;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Lanes covered by the registered size starting at the address byte offset;
    // a reset in the same cycle drops the write.
    always_comb begin
        be = '0;
        if (state_q == ST_DATA && write_q && !HRESET) begin
            for (int b = 0; b < BYTES; b++) begin
                if (b >= int'(boff_q) && b < int'(boff_q) + (1 << size_q)) be[b] = 1'b1;
            end
        end
    end

    ahb3lite_be_mem #(
        .DEPTH (MEM_DEPTH),
        .DW    (HDATA_SIZE),
        .AW    (AW)
    ) u_mem (
        .clk_i   (HCLK),
        .be_i    (be),
        .waddr_i (widx_q),
        .wdata_i (HWDATA),
        .raddr_i (widx_q),
        .rdata_o (rdata)
    );

    assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (state_q == ST_DATA && !write_q) ? rdata : '0;

endmodule

// File: doc/ahb3lite_sram_ws.md
AHB3LITE_SRAM_WS -- requirements
Module: ahb3lite_sram_ws

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of HDATA_SIZE-bit words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, HREADYOUT-low cycles inserted per OKAY transfer.
REQ-005 SHALL have parameter BASE_ADDR, default 0, byte address of word 0.
REQ-006 SHALL have ports: HCLK in 1, clock; HRESET in 1, synchronous active-high reset.
REQ-007 SHALL have ports: HSEL in 1, select; HADDR in HADDR_SIZE, address; HWRITE in 1, write.
REQ-008 SHALL have ports: HSIZE in 3, size; HBURST in 3, burst (ignored); HPROT in 4, protection (ignored).
REQ-009 SHALL have ports: HTRANS in 2, transfer type; HREADY in 1, bus ready.
REQ-010 SHALL have ports: HWDATA in HDATA_SIZE, write data; HRDATA out HDATA_SIZE, read data.
REQ-011 SHALL have ports: HREADYOUT out 1, slave ready; HRESP out 1, 0=OKAY, 1=ERROR.
REQ-012 SHALL use one clock, HCLK; reset HRESET is synchronous and active-high.

Function
REQ-013 SHALL accept a transfer when HSEL & HREADY & HTRANS in {NONSEQ,SEQ} at a rising HCLK edge, registering HADDR, HWRITE and HSIZE.
REQ-014 SHALL treat IDLE/BUSY, or HSEL=0, as no transfer, with zero-wait OKAY.
REQ-015 SHALL flag an error when (HADDR-BASE_ADDR) >= MEM_DEPTH*HDATA_SIZE/8, when HADDR < BASE_ADDR, when HADDR is misaligned to HSIZE, or when 8<<HSIZE > HDATA_SIZE.
REQ-016 SHALL implement FSM states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-017 SHALL transition from IDLE/DATA/ERR2 on an accepted transfer: error -> ERR1; else WAIT_STATES>0 -> WAIT with counter loaded to WAIT_STATES-1; else -> DATA. With no accepted transfer -> IDLE.
REQ-018 SHALL transition WAIT -> DATA when counter is 0, otherwise decrement the counter.
REQ-019 SHALL transition ERR1 -> ERR2 unconditionally.
REQ-020 SHALL drive HREADYOUT=0 in WAIT and ERR1 and 1 otherwise; HRESP=1 in ERR1/ERR2 and 0 otherwise.
REQ-021 SHALL commit a write to memory at the DATA-state edge using byte enables derived from the registered HSIZE and address low bits (little-endian); unselected lanes SHALL be unchanged.
REQ-022 SHALL drive HRDATA = full word at the registered address in DATA for reads, and 0 in all other states.
REQ-023 SHALL provide back-to-back reads/writes with no idle cycle; a read immediately following a write to the same word SHALL return the new data.
REQ-024 SHALL NOT modify memory on an errored transfer.
REQ-025 SHALL be able to accept a new transfer in ERR2 (master may cancel with IDLE during ERR1).

Reset
REQ-026 SHALL, while HRESET=1, put the FSM in IDLE with counter 0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-027 SHALL discard any in-flight write on reset mid-transfer; memory contents are not reset.

Structure
REQ-028 SHALL take HTRANS/HSIZE/HRESP encodings and the FSM state enum from shared package ahb3lite_pkg.
REQ-029 SHALL instantiate sub-module ahb3lite_be_mem (MEM_DEPTH x HDATA_SIZE array, per-byte write enable, combinational read).
REQ-030 SHALL fit in 120-400 lines of RTL.

Verification
REQ-031 SHALL test WAIT_STATES=0 with a write of 0xDEADBEEF to 0x10 followed back-to-back by a read of 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT never low.
REQ-032 SHALL test WAIT_STATES=3 with a read of 0x04 -> HREADYOUT low exactly 3 cycles, then data, HRESP=0.
REQ-033 SHALL test a byte write of 0xAA to 0x21 after word 0x20=0x00000000 -> reading 0x20 returns 0x0000AA00.
REQ-034 SHALL test a read at 0x400 (MEM_DEPTH=256, 32-bit) -> ERR1 with HREADYOUT=0/HRESP=1, then ERR2 with HREADYOUT=1/HRESP=1, memory unchanged.
REQ-035 SHALL test a halfword write at 0x03 -> two-cycle ERROR, and the next NONSEQ accepted in ERR2 completes OKAY.
REQ-036 SHALL test HRESET asserted during WAIT of a write to 0x08 -> outputs at reset values next edge, word 0x08 unchanged.
